// File: rtl/chacha_block_ctrl.sv
// chacha_block_ctrl: sequences the ChaCha20 block function over one shared,
// external quarter-round datapath. Holds the input copy and the working
// state, issues column/diagonal operand sets, writes results back, and
// finally adds the input state word-wise to produce the keystream block.
//
// Handshake summary:
//   start/busy : start is sampled only while busy=0 (IDLE); busy rises the
//                cycle after acceptance and falls in the cycle done is high.
//   done       : one-cycle pulse; out_state is valid from then on and held
//                until the next done.
//   qr_*       : operands are registered when leaving ISSUE. qr_finish seen
//                on the first WAIT edge belongs to the previous operands and
//                is dropped; the first qr_finish after that is accepted and
//                qr_out_* are sampled on that edge only.
module chacha_block_ctrl #(
    parameter int ROUNDS = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [511:0] in_state,
    output logic         busy,
    output logic         done,
    output logic [511:0] out_state,
    output logic [31:0]  qr_a,
    output logic [31:0]  qr_b,
    output logic [31:0]  qr_c,
    output logic [31:0]  qr_d,
    input  logic [31:0]  qr_out_a,
    input  logic [31:0]  qr_out_b,
    input  logic [31:0]  qr_out_c,
    input  logic [31:0]  qr_out_d,
    input  logic         qr_finish,
    output logic [1:0]   state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        FINAL = 2'd3
    } state_t;

    // Index of the last double round (ROUNDS/2 - 1).
    localparam logic [3:0] LAST_DR = 4'(ROUNDS / 2 - 1);

    state_t        state_q, state_d;
    logic [31:0]   init_q [16];
    logic [31:0]   init_d [16];
    logic [31:0]   work_q [16];
    logic [31:0]   work_d [16];
    logic [2:0]    qr_idx_q, qr_idx_d;
    logic [3:0]    dr_cnt_q, dr_cnt_d;
    logic          skip_q, skip_d;
    logic          done_q, done_d;
    logic [511:0]  out_q, out_d;
    logic [31:0]   qa_q, qa_d;
    logic [31:0]   qb_q, qb_d;
    logic [31:0]   qc_q, qc_d;
    logic [31:0]   qd_q, qd_d;

    logic [15:0]   sel;
    logic [3:0]    sel_a, sel_b, sel_c, sel_d;

    // Word indices {a,b,c,d} for each quarter round of a double round:
    // 0..3 are columns, 4..7 are diagonals.
    function automatic logic [15:0] sched(input logic [2:0] idx);
        logic [15:0] s;
        case (idx)
            3'd0:    s = {4'd0, 4'd4, 4'd8,  4'd12};
            3'd1:    s = {4'd1, 4'd5, 4'd9,  4'd13};
            3'd2:    s = {4'd2, 4'd6, 4'd10, 4'd14};
            3'd3:    s = {4'd3, 4'd7, 4'd11, 4'd15};
            3'd4:    s = {4'd0, 4'd5, 4'd10, 4'd15};
            3'd5:    s = {4'd1, 4'd6, 4'd11, 4'd12};
            3'd6:    s = {4'd2, 4'd7, 4'd8,  4'd13};
            default: s = {4'd3, 4'd4, 4'd9,  4'd14};
        endcase
        return s;
    endfunction

    assign sel   = sched(qr_idx_q);
    assign sel_a = sel[15:12];
    assign sel_b = sel[11:8];
    assign sel_c = sel[7:4];
    assign sel_d = sel[3:0];

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign out_state = out_q;
    assign qr_a      = qa_q;
    assign qr_b      = qb_q;
    assign qr_c      = qc_q;
    assign qr_d      = qd_q;
    assign state_dbg = state_q;

    // Next-state and register-update logic for the round sequencer.
    always_comb begin
        state_d  = state_q;
        init_d   = init_q;
        work_d   = work_q;
        qr_idx_d = qr_idx_q;
        dr_cnt_d = dr_cnt_q;
        skip_d   = skip_q;
        done_d   = 1'b0;
        out_d    = out_q;
        qa_d     = qa_q;
        qb_d     = qb_q;
        qc_d     = qc_q;
        qd_d     = qd_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < 16; i++) begin
                        init_d[i] = in_state[32*i +: 32];
                        work_d[i] = in_state[32*i +: 32];
                    end
                    qr_idx_d = 3'd0;
                    dr_cnt_d = 4'd0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                qa_d    = work_q[sel_a];
                qb_d    = work_q[sel_b];
                qc_d    = work_q[sel_c];
                qd_d    = work_q[sel_d];
                skip_d  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (skip_q) begin
                    // A finish here still reflects the previous operands.
                    skip_d = 1'b0;
                end else if (qr_finish) begin
                    work_d[sel_a] = qr_out_a;
                    work_d[sel_b] = qr_out_b;
                    work_d[sel_c] = qr_out_c;
                    work_d[sel_d] = qr_out_d;
                    if (qr_idx_q == 3'd7 && dr_cnt_q == LAST_DR) begin
                        state_d = FINAL;
                    end else begin
                        qr_idx_d = qr_idx_q + 3'd1;
                        if (qr_idx_q == 3'd7) begin
                            dr_cnt_d = dr_cnt_q + 4'd1;
                        end
                        state_d = ISSUE;
                    end
                end
            end
            FINAL: begin
                for (int i = 0; i < 16; i++) begin
                    out_d[32*i +: 32] = work_q[i] + init_q[i];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset discards any block in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            for (int i = 0; i < 16; i++) begin
                init_q[i] <= '0;
                work_q[i] <= '0;
            end
            qr_idx_q <= '0;
            dr_cnt_q <= '0;
            skip_q   <= 1'b0;
            done_q   <= 1'b0;
            out_q    <= '0;
            qa_q     <= '0;
            qb_q     <= '0;
            qc_q     <= '0;
            qd_q     <= '0;
        end else begin
            state_q  <= state_d;
            init_q   <= init_d;
            work_q   <= work_d;
            qr_idx_q <= qr_idx_d;
            dr_cnt_q <= dr_cnt_d;
            skip_q   <= skip_d;
            done_q   <= done_d;
            out_q    <= out_d;
            qa_q     <= qa_d;
            qb_q     <= qb_d;
            qc_q     <= qc_d;
            qd_q     <= qd_d;
        end
    end

endmodule

// File: tb/tb_chacha_block_ctrl.sv
// Bench for chacha_block_ctrl: drives blocks with a behavioural quarter-round
// datapath whose finish pulse free-runs with interval P, and checks operands,
// results, latency and control pulses against a ChaCha20 reference model.
module tb_chacha_block_ctrl;

    localparam int ROUNDS = 20;
    localparam int NQR    = 4 * ROUNDS;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [511:0] in_state;
    logic         busy, done;
    logic [511:0] out_state;
    logic [31:0]  qr_a, qr_b, qr_c, qr_d;
    logic [31:0]  qr_out_a, qr_out_b, qr_out_c, qr_out_d;
    logic         qr_finish;
    logic [1:0]   state_dbg;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int p_int = 1;
    int dp_cnt = 0;
    int cyc = 0;
    int start_cyc = 0;

    logic [127:0] prev_ops = '0;
    logic [127:0] garb = '0;
    logic         fin_s = 1'b0;
    logic [127:0] dp_res;
    logic [511:0] last_out = '0;

    logic [127:0] ops_q[$];
    logic [511:0] exp_q[$];

    int sch [8][4] = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
                       '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};

    logic [31:0] rfc_w [16] = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
                                32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                                32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
                                32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
    logic [511:0] rfc;

    chacha_block_ctrl #(.ROUNDS(ROUNDS)) dut (
        .clk(clk), .rst(rst), .start(start), .in_state(in_state),
        .busy(busy), .done(done), .out_state(out_state),
        .qr_a(qr_a), .qr_b(qr_b), .qr_c(qr_c), .qr_d(qr_d),
        .qr_out_a(qr_out_a), .qr_out_b(qr_out_b), .qr_out_c(qr_out_c), .qr_out_d(qr_out_d),
        .qr_finish(qr_finish), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] qr_fn(input logic [127:0] v);
        logic [31:0] a, b, c, d;
        {a, b, c, d} = v;
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    // Datapath model: result is only meaningful once operands have been
    // stable for a cycle; before that it returns garbage.
    assign qr_finish = (dp_cnt == 0);
    assign dp_res = ({qr_a, qr_b, qr_c, qr_d} == prev_ops) ? qr_fn({qr_a, qr_b, qr_c, qr_d}) : garb;
    assign {qr_out_a, qr_out_b, qr_out_c, qr_out_d} = dp_res;

    always @(posedge clk) begin
        dp_cnt   <= (dp_cnt >= p_int) ? 0 : dp_cnt + 1;
        prev_ops <= {qr_a, qr_b, qr_c, qr_d};
        garb     <= {$urandom, $urandom, $urandom, $urandom};
        fin_s    <= qr_finish;
        cyc      <= cyc + 1;
        if (start && !busy && !rst) start_cyc <= cyc;
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: full ChaCha block, recording every operand set.
    task automatic model_push(input logic [511:0] st);
        logic [31:0] x [16];
        logic [127:0] v;
        logic [511:0] res;
        for (int i = 0; i < 16; i++) x[i] = st[32*i +: 32];
        for (int dr = 0; dr < ROUNDS / 2; dr++) begin
            for (int q = 0; q < 8; q++) begin
                v = {x[sch[q][0]], x[sch[q][1]], x[sch[q][2]], x[sch[q][3]]};
                ops_q.push_back(v);
                {x[sch[q][0]], x[sch[q][1]], x[sch[q][2]], x[sch[q][3]]} = qr_fn(v);
            end
        end
        for (int i = 0; i < 16; i++) res[32*i +: 32] = x[i] + st[32*i +: 32];
        exp_q.push_back(res);
    endtask

    // driver tasks
    task automatic launch(input logic [511:0] st);
        @(negedge clk);
        in_state = st;
        start = 1'b1;
        model_push(st);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < (p_int + 4) * NQR + 50) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (done_cnt < target) begin
            errors++;
            $display("FAIL done_timeout actual=%0d expected=%0d", done_cnt, target);
        end
    endtask

    task automatic chk_rfc(input string tag);
        chk({tag, "_w0"}, 512'(out_state[31:0]), 512'(32'he4e7f110));
        chk({tag, "_w15"}, 512'(out_state[511:480]), 512'(32'h4e3c50a2));
    endtask

    // scoreboard monitor
    initial begin
        logic [1:0] prev_dbg = S_IDLE;
        logic prev_done = 1'b0;
        int wait_len = 0;
        int lat;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_dbg = S_IDLE;
                prev_done = 1'b0;
                wait_len = 0;
            end else begin
                if (prev_dbg == S_WAIT && state_dbg != S_WAIT) begin
                    chk("accept_had_finish", 512'(fin_s), 512'(1'b1));
                    chk("accept_after_stale_cycle", 512'(wait_len >= 2), 512'(1'b1));
                end
                if (state_dbg == S_WAIT) wait_len = (prev_dbg == S_WAIT) ? wait_len + 1 : 1;
                if (prev_dbg == S_ISSUE && state_dbg == S_WAIT) begin
                    if (ops_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL qr_ops_unexpected actual=%0h expected=none", {qr_a, qr_b, qr_c, qr_d});
                    end else begin
                        chk("qr_ops", 512'({qr_a, qr_b, qr_c, qr_d}), 512'(ops_q.pop_front()));
                    end
                end
                if (done) begin
                    done_cnt++;
                    chk("done_single_cycle", 512'(prev_done), 512'(1'b0));
                    chk("busy_low_with_done", 512'(busy), 512'(1'b0));
                    chk("all_qr_issued", 512'(ops_q.size()), 512'(0));
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL done_unexpected actual=%0h expected=none", out_state);
                    end else begin
                        last_out = exp_q.pop_front();
                        chk("out_state", out_state, last_out);
                    end
                    lat = cyc - start_cyc - 1;
                    chk("latency_min", 512'(lat >= 3 * NQR + 1), 512'(1'b1));
                    chk("latency_max", 512'(lat <= (p_int + 3) * NQR + 1), 512'(1'b1));
                end else begin
                    chk("out_state_held", out_state, last_out);
                end
                prev_dbg = state_dbg;
                prev_done = done;
            end
        end
    end

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    // stimulus
    initial begin
        logic [511:0] st_a, st_b;
        int n;
        for (int i = 0; i < 16; i++) rfc[32*i +: 32] = rfc_w[i];
        rst = 1'b1;
        start = 1'b0;
        in_state = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 512'(busy), 512'(1'b0));
        chk("rst_done", 512'(done), 512'(1'b0));
        chk("rst_out", out_state, 512'd0);
        chk("rst_qr", 512'({qr_a, qr_b, qr_c, qr_d}), 512'd0);
        @(negedge clk);
        rst = 1'b0;

        // RFC vector, P=1
        p_int = 1;
        launch(rfc);
        wait_done(1);
        chk_rfc("rfc_p1");

        // interval sweep with the same vector
        foreach (sch[k]) begin
            if (k < 3) begin
                p_int = (k == 0) ? 0 : ((k == 1) ? 3 : 7);
                launch(rfc);
                wait_done(done_cnt + 1);
                chk_rfc($sformatf("rfc_p%0d", p_int));
            end
        end

        // random states and intervals
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 16; i++) st_a[32*i +: 32] = $urandom;
            p_int = $urandom_range(0, 4);
            launch(st_a);
            wait_done(done_cnt + 1);
        end

        // start while busy is ignored
        p_int = 1;
        for (int i = 0; i < 16; i++) st_a[32*i +: 32] = $urandom;
        for (int i = 0; i < 16; i++) st_b[32*i +: 32] = $urandom;
        n = done_cnt;
        launch(st_a);
        repeat (3) @(negedge clk);
        in_state = st_b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (44) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n + 1);
        repeat (30) @(posedge clk);
        chk("busy_start_single_done", 512'(done_cnt), 512'(n + 1));

        // back-to-back: start raised in the done cycle
        launch(st_b);
        n = 0;
        @(negedge clk);
        while (!done && n < 4 * NQR + 50) begin
            @(negedge clk);
            n++;
        end
        in_state = rfc; start = 1'b1;
        model_push(rfc);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", 512'(busy), 512'(1'b1));
        wait_done(done_cnt + 1);
        chk_rfc("rfc_b2b");

        // asynchronous reset mid-block
        launch(st_a);
        repeat (100) @(posedge clk);
        #2;
        rst = 1'b1;
        last_out = '0;
        #1;
        chk("midrst_busy", 512'(busy), 512'(1'b0));
        chk("midrst_done", 512'(done), 512'(1'b0));
        chk("midrst_out", out_state, 512'd0);
        chk("midrst_qr", 512'({qr_a, qr_b, qr_c, qr_d}), 512'd0);
        ops_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = done_cnt;
        launch(rfc);
        wait_done(n + 1);
        chk_rfc("rfc_after_rst");

        repeat (5) @(posedge clk);
        chk("exp_q_empty", 512'(exp_q.size()), 512'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
